// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch display path: active-low segment
// patterns ({g,f,e,d,c,b,a}) and the digit-slot index type.
package stopwatch_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    DIG_S0 = 2'd0,
    DIG_S1 = 2'd1,
    DIG_M0 = 2'd2,
    DIG_M1 = 2'd3
  } digit_idx_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder; codes above 9 show a dash.
module seg7_decode
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/stopwatch_display_scan.sv
// Multiplexed 4-digit scan driver for the stopwatch: frame-synchronous
// snapshot, per-slot dead time, minutes blink, leading-zero blank, registered outputs.
module stopwatch_display_scan
  import stopwatch_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYC    = 2,
  parameter int BLINK_DIV   = 12500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit_S0,
  input  logic [3:0] digit_S1,
  input  logic [3:0] digit_M0,
  input  logic [3:0] digit_M1,
  input  logic       M_set,
  input  logic       lap_hold,
  input  logic       lz_blank,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [RW-1:0]     refresh_cnt, refresh_cnt_nxt;
  logic [BW-1:0]     blink_cnt, blink_cnt_nxt;
  logic              blink_ph, blink_ph_nxt;
  digit_idx_t        idx, idx_nxt;
  logic [3:0][3:0]   snap, snap_nxt;
  logic [3:0]        an_nxt;
  logic [6:0]        seg_nxt;
  logic              dp_nxt;
  logic [3:0]        cur_digit;
  logic [6:0]        cur_code;
  logic              refresh_end;
  logic              blank;

  assign cur_digit = snap[idx];

  seg7_decode u_decode (
    .bcd (cur_digit),
    .seg (cur_code)
  );

  always_comb begin
    refresh_cnt_nxt = refresh_cnt;
    blink_cnt_nxt   = blink_cnt;
    blink_ph_nxt    = blink_ph;
    idx_nxt         = idx;
    snap_nxt        = snap;
    an_nxt          = 4'b1111;
    seg_nxt         = SEG_BLANK;
    dp_nxt          = 1'b1;
    blank           = 1'b0;

    refresh_end = (refresh_cnt == RW'(REFRESH_DIV - 1));
    if (refresh_end) begin
      refresh_cnt_nxt = '0;
      idx_nxt         = digit_idx_t'(2'(idx + 2'd1));
    end else begin
      refresh_cnt_nxt = refresh_cnt + RW'(1);
    end

    // Snapshot only at the frame boundary so a frame never mixes old and new digits
    if (refresh_end && (idx == DIG_M1) && !lap_hold)
      snap_nxt = {digit_M1, digit_M0, digit_S1, digit_S0};

    if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt_nxt = '0;
      blink_ph_nxt  = ~blink_ph;
    end else begin
      blink_cnt_nxt = blink_cnt + BW'(1);
    end

    blank = (refresh_cnt < RW'(DEAD_CYC))
         || ((idx inside {DIG_M0, DIG_M1}) && M_set && blink_ph)
         || ((idx == DIG_M1) && lz_blank && (snap[3] == 4'd0));

    if (!blank) begin
      an_nxt[idx] = 1'b0;
      seg_nxt     = cur_code;
      dp_nxt      = (idx != DIG_M0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      refresh_cnt <= '0;
      blink_cnt   <= '0;
      blink_ph    <= 1'b0;
      idx         <= DIG_S0;
      snap        <= '0;
      an          <= 4'b1111;
      seg         <= SEG_BLANK;
      dp          <= 1'b1;
    end else begin
      refresh_cnt <= refresh_cnt_nxt;
      blink_cnt   <= blink_cnt_nxt;
      blink_ph    <= blink_ph_nxt;
      idx         <= idx_nxt;
      snap        <= snap_nxt;
      an          <= an_nxt;
      seg         <= seg_nxt;
      dp          <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_stopwatch_display_scan.sv
// Self-checking bench for stopwatch_display_scan: directed scenarios plus random
// input traffic, compared every cycle against a frame-level reference model.
module tb_stopwatch_display_scan;

  localparam int REFRESH_DIV = 4;
  localparam int DEAD_CYC    = 1;
  localparam int BLINK_DIV   = 16;
  localparam int FRAME       = 4 * REFRESH_DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] digit_S0 = '0, digit_S1 = '0, digit_M0 = '0, digit_M1 = '0;
  logic       M_set = 1'b0, lap_hold = 1'b0, lz_blank = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int errors = 0;
  int n = 0;
  int snap_m[4];

  always #5 clk = ~clk;

  stopwatch_display_scan #(
    .REFRESH_DIV (REFRESH_DIV),
    .DEAD_CYC    (DEAD_CYC),
    .BLINK_DIV   (BLINK_DIV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .digit_S0 (digit_S0),
    .digit_S1 (digit_S1),
    .digit_M0 (digit_M0),
    .digit_M1 (digit_M1),
    .M_set    (M_set),
    .lap_hold (lap_hold),
    .lz_blank (lz_blank),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  function automatic logic [6:0] code_of(int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  task automatic checkOutput(string tag, logic [3:0] e_an, logic [6:0] e_seg, logic e_dp);
    checks++;
    assert (an === e_an) else begin
      errors++;
      $error("[TB] FAIL %s an observed=%b expected=%b (t=%0t)", tag, an, e_an, $time);
    end
    checks++;
    assert (seg === e_seg) else begin
      errors++;
      $error("[TB] FAIL %s seg observed=%b expected=%b (t=%0t)", tag, seg, e_seg, $time);
    end
    checks++;
    assert (dp === e_dp) else begin
      errors++;
      $error("[TB] FAIL %s dp observed=%b expected=%b (t=%0t)", tag, dp, e_dp, $time);
    end
  endtask

  task automatic model_reset();
    n = 0;
    for (int i = 0; i < 4; i++) snap_m[i] = 0;
  endtask

  task automatic set_inputs(int m1, int m0, int s1, int s0);
    digit_M1 = 4'(m1);
    digit_M0 = 4'(m0);
    digit_S1 = 4'(s1);
    digit_S0 = 4'(s0);
  endtask

  // Each cycle: predict from the model's time position, clock once, then compare
  task automatic applyStimulus(int cycles, string tag);
    for (int c = 0; c < cycles; c++) begin
      int         cnt;
      int         slot;
      bit         blank;
      bit         load;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic       e_dp;
      cnt   = n % REFRESH_DIV;
      slot  = (n / REFRESH_DIV) % 4;
      blank = (cnt < DEAD_CYC)
           || (slot >= 2 && M_set == 1'b1 && ((n / BLINK_DIV) % 2) == 1)
           || (slot == 3 && lz_blank == 1'b1 && snap_m[3] == 0);
      e_an = 4'b1111;
      if (!blank) e_an[slot] = 1'b0;
      e_seg = blank ? 7'b1111111 : code_of(snap_m[slot]);
      e_dp  = !(slot == 2 && !blank);
      load  = ((n % FRAME) == FRAME - 1) && (lap_hold == 1'b0);
      @(posedge clk);
      if (load) begin
        snap_m[0] = int'(digit_S0);
        snap_m[1] = int'(digit_S1);
        snap_m[2] = int'(digit_M0);
        snap_m[3] = int'(digit_M1);
      end
      n++;
      #1;
      checkOutput(tag, e_an, e_seg, e_dp);
    end
  endtask

  task automatic align_to(int phase, string tag);
    applyStimulus(((phase - (n % FRAME)) + FRAME) % FRAME, tag);
  endtask

  initial begin
    set_inputs(1, 2, 3, 4);
    #12;
    checkOutput("reset_state", 4'b1111, 7'b1111111, 1'b1);

    @(negedge clk);
    reset = 1'b1;
    model_reset();
    applyStimulus(2 * FRAME, "first_frames");

    // Snapshot must not tear when inputs change mid-frame
    set_inputs(5, 9, 5, 9);
    align_to(0, "align_5959");
    applyStimulus(FRAME + 5, "load_5959");
    set_inputs(0, 0, 0, 0);
    applyStimulus(2 * FRAME - 5, "midframe_change");

    set_inputs(0, 0, 0, 5);
    applyStimulus(FRAME, "load_0005");
    lap_hold = 1'b1;
    applyStimulus(3, "lap_hold_on");
    set_inputs(0, 1, 1, 0);
    applyStimulus(2 * FRAME, "lap_hold_frozen");
    lap_hold = 1'b0;
    applyStimulus(2 * FRAME, "lap_hold_release");

    M_set = 1'b1;
    applyStimulus(4 * FRAME, "minutes_blink");
    M_set = 1'b0;

    set_inputs(0, 7, 3, 12);
    lz_blank = 1'b1;
    applyStimulus(2 * FRAME, "lz_blank_dash");
    lz_blank = 1'b0;

    for (int r = 0; r < 60; r++) begin
      set_inputs($urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 15), $urandom_range(0, 15));
      lap_hold = ($urandom_range(0, 3) == 0);
      M_set    = 1'($urandom_range(0, 1));
      lz_blank = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) digit_M1 = 4'd0;
      applyStimulus($urandom_range(1, 12), "random");
    end
    lap_hold = 1'b0;
    M_set    = 1'b0;
    lz_blank = 1'b0;
    set_inputs(4, 8, 2, 6);
    applyStimulus(2 * FRAME, "pre_async");

    // Mid-slot of M0: outputs are showing a digit before reset hits
    align_to(2 * REFRESH_DIV + 2, "align_async");
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_reset", 4'b1111, 7'b1111111, 1'b1);
    @(negedge clk);
    checkOutput("reset_hold", 4'b1111, 7'b1111111, 1'b1);
    reset = 1'b1;
    model_reset();
    applyStimulus(1, "post_reset_dead");
    applyStimulus(2 * FRAME + 3, "post_reset_scan");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
